// File: rtl/systolic_pkg.sv
// +----------------------------------------------------------------------------+
// | systolic_pkg : shared constants, FSM states and helpers for the feeder     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package systolic_pkg;

    localparam int          DEF_N     = 4;
    localparam int          DEF_DW    = 32;
    localparam logic [31:0] FP_ZERO   = 32'h0;
    localparam int          FEED_LEN  = 3 * DEF_N - 2;
    localparam int          DRAIN_LEN = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_if.sv
// +----------------------------------------------------------------------------+
// | systolic_feeder_if : host load/start bus and PE operand/control outputs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
);

    logic            load_valid;
    logic            load_ready;
    logic            load_sel;
    logic [DW-1:0]   load_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] a_feed;
    logic [N*DW-1:0] b_feed;
    logic            en_mult;
    logic            clr_mult;
    logic            en_accum;
    logic            clr_accum;

    modport master (
        output load_valid, load_sel, load_data, start,
        input  load_ready, busy, done, a_feed, b_feed,
               en_mult, clr_mult, en_accum, clr_accum
    );

    modport slave (
        input  load_valid, load_sel, load_data, start,
        output load_ready, busy, done, a_feed, b_feed,
               en_mult, clr_mult, en_accum, clr_accum
    );

endinterface

`default_nettype wire

// File: rtl/feeder_lane.sv
// +----------------------------------------------------------------------------+
// | feeder_lane : picks element t-IDX of one row/column, zero outside window   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module feeder_lane
    import systolic_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int DW  = DEF_DW,
    parameter int IDX = 0,
    parameter int TW  = 4
) (
    input  logic [TW-1:0] t,
    input  logic [DW-1:0] elems [N],
    output logic [DW-1:0] data
);

    always_comb begin
        data = DW'(FP_ZERO);
        for (int k = 0; k < N; k++) begin
            if (int'(t) == IDX + k) begin
                data = elems[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// +----------------------------------------------------------------------------+
// | systolic_feeder : buffers A/B, skews them into the array, sequences PEs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    systolic_feeder_if.slave  bus
);

    localparam int C_NN    = N * N;
    localparam int C_PW    = $clog2(C_NN);
    localparam int C_CW    = $clog2(C_NN + 1);
    localparam int C_FLEN  = feed_len(N);
    localparam int C_TW    = $clog2(C_FLEN + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [C_TW-1:0]   r_cnt;
    logic [C_TW-1:0]   w_cnt_nxt;

    logic [DW-1:0]     r_a [C_NN];
    logic [DW-1:0]     r_b [C_NN];
    logic [C_PW-1:0]   r_a_ptr;
    logic [C_PW-1:0]   r_b_ptr;
    logic [C_CW-1:0]   r_a_fill;
    logic [C_CW-1:0]   r_b_fill;

    logic [N*DW-1:0]   r_a_feed;
    logic [N*DW-1:0]   r_b_feed;
    logic [N*DW-1:0]   w_a_feed_nxt;
    logic [N*DW-1:0]   w_b_feed_nxt;

    logic              w_load;
    logic              w_full;

    assign w_load = bus.load_valid && bus.load_ready;
    // Uses registered counts, so a load in the start cycle cannot complete the fill
    assign w_full = (r_a_fill == C_CW'(C_NN)) && (r_b_fill == C_CW'(C_NN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.start && w_full) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                w_state_nxt = FEED;
                w_cnt_nxt   = '0;
            end
            FEED: begin
                if (r_cnt == C_TW'(C_FLEN - 1)) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_TW'(1);
                end
            end
            DRAIN: begin
                if (r_cnt == C_TW'(DRAIN_LEN - 1)) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_TW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < C_NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_a_ptr  <= '0;
            r_b_ptr  <= '0;
            r_a_fill <= '0;
            r_b_fill <= '0;
        end else if (w_load) begin
            if (!bus.load_sel) begin
                r_a[r_a_ptr] <= bus.load_data;
                r_a_ptr      <= (r_a_ptr == C_PW'(C_NN - 1)) ? '0 : r_a_ptr + C_PW'(1);
                if (r_a_fill != C_CW'(C_NN)) r_a_fill <= r_a_fill + C_CW'(1);
            end else begin
                r_b[r_b_ptr] <= bus.load_data;
                r_b_ptr      <= (r_b_ptr == C_PW'(C_NN - 1)) ? '0 : r_b_ptr + C_PW'(1);
                if (r_b_fill != C_CW'(C_NN)) r_b_fill <= r_b_fill + C_CW'(1);
            end
        end
    end

    // Lanes look one cycle ahead so the registered feed holds the value for t
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] w_a_elems [N];
        logic [DW-1:0] w_b_elems [N];
        logic [DW-1:0] w_a_out;
        logic [DW-1:0] w_b_out;

        for (genvar gk = 0; gk < N; gk++) begin : g_elem
            assign w_a_elems[gk] = r_a[gi * N + gk];
            assign w_b_elems[gk] = r_b[gk * N + gi];
        end

        feeder_lane #(.N(N), .DW(DW), .IDX(gi), .TW(C_TW)) u_a_lane (
            .t     (w_cnt_nxt),
            .elems (w_a_elems),
            .data  (w_a_out)
        );

        feeder_lane #(.N(N), .DW(DW), .IDX(gi), .TW(C_TW)) u_b_lane (
            .t     (w_cnt_nxt),
            .elems (w_b_elems),
            .data  (w_b_out)
        );

        assign w_a_feed_nxt[gi*DW +: DW] = (w_state_nxt == FEED) ? w_a_out : '0;
        assign w_b_feed_nxt[gi*DW +: DW] = (w_state_nxt == FEED) ? w_b_out : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_feed <= '0;
            r_b_feed <= '0;
        end else begin
            r_a_feed <= w_a_feed_nxt;
            r_b_feed <= w_b_feed_nxt;
        end
    end

    assign bus.load_ready = (r_state == IDLE);
    assign bus.busy       = (r_state == CLEAR) || (r_state == FEED) || (r_state == DRAIN);
    assign bus.done       = (r_state == DONE);
    assign bus.a_feed     = r_a_feed;
    assign bus.b_feed     = r_b_feed;
    assign bus.en_mult    = (r_state == FEED);
    assign bus.clr_mult   = (r_state == CLEAR);
    assign bus.clr_accum  = (r_state == CLEAR);
    // Accumulate trails multiply by one cycle to cover the multiplier register
    assign bus.en_accum   = ((r_state == FEED) && (r_cnt != '0)) ||
                            ((r_state == DRAIN) && (r_cnt == '0));

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Writer side of the PE operand/control interface for the NxN systolic matrix-multiply array.
- Buffers one NxN matrix A and one NxN matrix B (32-bit IEEE-754 words).
- On start, injects A rows on the array's west edge (PE a_in) and B columns on the north edge (PE b_in) with diagonal skew.
- Sequences the PE mult/accum enables and clears, so PE(i,j) finishes holding C[i][j].

Parameters:
- N, 4, array dimension (rows = cols = N).
- DW, 32, operand word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load word present.
- load_ready  out  1  feeder accepts load words; high only in IDLE.
- load_sel  in  1  0 = write A, 1 = write B.
- load_data  in  DW  matrix element, row-major order.
- start  in  1  begin a multiply; one-cycle pulse or level.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are final in all PEs.
- a_feed  out  N*DW  lane i (bits i*DW +: DW) drives a_in of PE(i,0).
- b_feed  out  N*DW  lane j drives b_in of PE(0,j).
- en_mult, clr_mult, en_accum, clr_accum  out  1 each  broadcast to every PE.

Behaviour:
- Reset: all outputs 0 except load_ready = 1; state IDLE; storage, write pointers and fill counts cleared. Reset asserted mid-operation aborts immediately to this state.
- Load:
  - Handshake is load_valid && load_ready.
  - The selected matrix writes at its own pointer (0..N*N-1, row-major), then the pointer increments.
  - At N*N the pointer wraps to 0 and the fill count saturates at N*N; later writes overwrite from element 0.
- Start acceptance: start is accepted only in IDLE with both fill counts = N*N; otherwise it is ignored (no state change).
  - If start and a load handshake occur in the same cycle, the load is performed and start is judged on the pre-load counts.
- States: IDLE -> CLEAR (1 cycle) -> FEED (3N-2 cycles) -> DRAIN (2 cycles) -> DONE (1 cycle) -> IDLE.
  - Start is accepted in cycle 0.
  - For N=4: CLEAR = cycle 1, FEED = cycles 2..11, DRAIN = 12..13, done = 1 in cycle 14.
  - busy = 1 in CLEAR, FEED and DRAIN; busy = 0 in DONE and IDLE.
- CLEAR: clr_mult = clr_accum = 1; all feeds 0.
- FEED, with feed counter t = 0..3N-3:
  - a_feed lane i = A[i][t-i] when 0 <= t-i < N, else 32'h0.
  - b_feed lane j = B[t-j][j] when 0 <= t-j < N, else 32'h0.
  - Feeds are registered outputs: values for t are present throughout the cycle in which the counter equals t.
  - Resulting arrival: A[i][k] and B[k][j] meet at PE(i,j) at t = i+j+k.
- Enables:
  - en_mult = 1 for all FEED cycles.
  - en_accum = 1 from FEED t=1 through DRAIN cycle 0; this is a one-cycle lag for the registered multiplier.
  - Both are 0 in all other states.
  - Zero operands outside the skew window contribute +0.0 and are harmless.
- DRAIN: feeds 0, en_mult 0.
- DONE: done = 1 for exactly one cycle. Matrices and fill counts are retained, so a new start reruns without reloading.
- While busy: load_ready = 0, load_valid is ignored, start is ignored.

Decomposition:
- Shared package systolic_pkg holds:
  - N and DW defaults.
  - The state enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - FP_ZERO = 32'h0.
  - Derived constants FEED_LEN = 3N-2 and DRAIN_LEN = 2.
- Sub-module feeder_lane, instantiated 2N times: given lane index, counter t and one stored row/column, outputs the element or FP_ZERO per the window rule.

Test Plan:
- Reset with rst_n low mid-cycle -> all outputs 0, load_ready = 1, busy = 0, independent of clk.
- Load only A (16 words) then pulse start -> busy stays 0, no clr pulse; load 16 B words, start -> clr_mult = clr_accum = 1 next cycle.
- Full run, N=4, A = identity (diagonal 32'h3F800000), B[r][c] = distinct tags 32'h0000_00rc:
  - done exactly 14 cycles after start.
  - en_mult high cycles 2..11; en_accum high cycles 3..12.
  - a_feed lane1 = 0 at t=0 and 32'h3F800000 at t=2.
  - b_feed lane3 = 32'h0000_0003 at t=3 and 32'h0000_0033 at t=6.
- In-flight hazards: start pulsed at t=4 -> ignored; load_valid at t=4 -> load_ready = 0 and storage unchanged (rerun gives identical feeds).
- Overwrite wrap: load 17 A words -> element A[0][0] equals word 17 and fill count stays 16; a rerun feeds the new A[0][0] on lane0 at t=0.
- Reset at FEED t=5 -> IDLE with all outputs 0; a subsequent start is ignored until both matrices are reloaded.
